// File: rtl/atm_card_auth_if.sv
// Bus between the ATM card-reader front end and atm_card_auth.
// Signalling: there is no valid/ready back-pressure on this bus. card_in,
// pin_strobe, session_end and tbl_wr_en are single-cycle strobes. They are
// sampled on the rising clock edge, and their data fields must be stable in
// that same cycle. acct_found, auth_ok, acct_idx, fail_count and busy are
// levels. pin_error, card_reject, card_retained and timeout are one-cycle pulses.
interface atm_card_auth_if #(
  parameter int ACCT_W = 12,
  parameter int PIN_W  = 12,
  parameter int IDX_W  = 2
);
  logic              card_in;
  logic [ACCT_W-1:0] acct_num;
  logic              pin_strobe;
  logic [PIN_W-1:0]  pin;
  logic              session_end;
  logic              tbl_wr_en;
  logic [IDX_W-1:0]  tbl_wr_idx;
  logic [ACCT_W-1:0] tbl_wr_acct;
  logic [PIN_W-1:0]  tbl_wr_pin;
  logic              busy;
  logic              acct_found;
  logic              auth_ok;
  logic [IDX_W-1:0]  acct_idx;
  logic [2:0]        fail_count;
  logic              pin_error;
  logic              card_reject;
  logic              card_retained;
  logic              timeout;

  modport master (
    output card_in, acct_num, pin_strobe, pin, session_end,
           tbl_wr_en, tbl_wr_idx, tbl_wr_acct, tbl_wr_pin,
    input  busy, acct_found, auth_ok, acct_idx, fail_count,
           pin_error, card_reject, card_retained, timeout
  );

  modport slave (
    input  card_in, acct_num, pin_strobe, pin, session_end,
           tbl_wr_en, tbl_wr_idx, tbl_wr_acct, tbl_wr_pin,
    output busy, acct_found, auth_ok, acct_idx, fail_count,
           pin_error, card_reject, card_retained, timeout
  );
endinterface

// File: rtl/atm_card_auth.sv
// Card/PIN authentication front end. It holds a small account table, looks up
// the inserted card, verifies the PIN and retains the card after repeated
// failures. The current FSM state is exported on state_o for observation.
module atm_card_auth #(
  parameter int NUM_ACCTS      = 3,
  parameter int ACCT_W         = 12,
  parameter int PIN_W          = 12,
  parameter int IDX_W          = 2,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst,
  atm_card_auth_if.slave bus,
  output logic [2:0]     state_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEARCH   = 3'd1;
  localparam logic [2:0] S_WAIT_PIN = 3'd2;
  localparam logic [2:0] S_CHECK    = 3'd3;
  localparam logic [2:0] S_GRANTED  = 3'd4;
  localparam logic [2:0] S_LOCK     = 3'd5;
  localparam logic [2:0] S_REJECT   = 3'd6;

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACCTS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       MAX_CNT  = 3'(MAX_TRIES);

  // Account table
  logic [ACCT_W-1:0] tbl_acct_q  [NUM_ACCTS];
  logic [PIN_W-1:0]  tbl_pin_q   [NUM_ACCTS];
  logic              tbl_valid_q [NUM_ACCTS];
  logic              tbl_lock_q  [NUM_ACCTS];

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              arm_q, arm_d;
  logic [ACCT_W-1:0] acct_q, acct_d;
  logic [PIN_W-1:0]  pin_q, pin_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [2:0]        fail_q, fail_d;
  logic              found_q, found_d;
  logic              auth_q, auth_d;
  logic [IDX_W-1:0]  aidx_q, aidx_d;
  logic              pin_error_q, pin_error_d;
  logic              reject_q, reject_d;
  logic              retained_q, retained_d;
  logic              timeout_q, timeout_d;

  logic              tbl_we;
  logic              lock_set;
  logic              entry_hit;
  logic              pin_ok;
  logic [2:0]        fail_inc;

  // Table writes are only honoured while idle and for existing entries.
  assign tbl_we    = (state_q == S_IDLE) && bus.tbl_wr_en &&
                     (int'(bus.tbl_wr_idx) < NUM_ACCTS);
  assign entry_hit = tbl_valid_q[idx_q] && (tbl_acct_q[idx_q] == acct_q);
  assign pin_ok    = (pin_q == tbl_pin_q[aidx_q]);
  assign fail_inc  = fail_q + 3'd1;

  // Next-state and output-register logic for the session FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    arm_d       = arm_q;
    acct_d      = acct_q;
    pin_d       = pin_q;
    timer_d     = timer_q;
    fail_d      = fail_q;
    found_d     = found_q;
    auth_d      = auth_q;
    aidx_d      = aidx_q;
    pin_error_d = 1'b0;
    reject_d    = 1'b0;
    retained_d  = 1'b0;
    timeout_d   = 1'b0;
    lock_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.card_in) begin
          acct_d  = bus.acct_num;
          idx_d   = '0;
          fail_d  = '0;
          arm_d   = 1'b1;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        // The first SEARCH cycle only settles the latched account number.
        // This places a match on entry k at k+2 cycles after card_in.
        if (arm_q) begin
          arm_d = 1'b0;
        end else if (entry_hit && !tbl_lock_q[idx_q]) begin
          found_d = 1'b1;
          aidx_d  = idx_q;
          timer_d = '0;
          state_d = S_WAIT_PIN;
        end else if (entry_hit || (idx_q == LAST_IDX)) begin
          reject_d = 1'b1;
          state_d  = S_REJECT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_WAIT_PIN: begin
        if (bus.pin_strobe) begin
          pin_d   = bus.pin;
          timer_d = '0;
          state_d = S_CHECK;
        end else if (timer_q == TMR_LAST) begin
          timeout_d = 1'b1;
          reject_d  = 1'b1;
          found_d   = 1'b0;
          aidx_d    = '0;
          state_d   = S_REJECT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_CHECK: begin
        if (pin_ok) begin
          auth_d  = 1'b1;
          state_d = S_GRANTED;
        end else if (fail_inc >= MAX_CNT) begin
          fail_d     = MAX_CNT;
          retained_d = 1'b1;
          lock_set   = 1'b1;
          found_d    = 1'b0;
          aidx_d     = '0;
          state_d    = S_LOCK;
        end else begin
          fail_d      = fail_inc;
          pin_error_d = 1'b1;
          timer_d     = '0;
          state_d     = S_WAIT_PIN;
        end
      end
      S_GRANTED: begin
        if (bus.session_end) begin
          found_d = 1'b0;
          auth_d  = 1'b0;
          aidx_d  = '0;
          state_d = S_IDLE;
        end
      end
      S_LOCK:   state_d = S_IDLE;
      S_REJECT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, output and table registers; reset also invalidates the table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      arm_q       <= 1'b0;
      acct_q      <= '0;
      pin_q       <= '0;
      timer_q     <= '0;
      fail_q      <= '0;
      found_q     <= 1'b0;
      auth_q      <= 1'b0;
      aidx_q      <= '0;
      pin_error_q <= 1'b0;
      reject_q    <= 1'b0;
      retained_q  <= 1'b0;
      timeout_q   <= 1'b0;
      for (int i = 0; i < NUM_ACCTS; i++) begin
        tbl_acct_q[i]  <= '0;
        tbl_pin_q[i]   <= '0;
        tbl_valid_q[i] <= 1'b0;
        tbl_lock_q[i]  <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      arm_q       <= arm_d;
      acct_q      <= acct_d;
      pin_q       <= pin_d;
      timer_q     <= timer_d;
      fail_q      <= fail_d;
      found_q     <= found_d;
      auth_q      <= auth_d;
      aidx_q      <= aidx_d;
      pin_error_q <= pin_error_d;
      reject_q    <= reject_d;
      retained_q  <= retained_d;
      timeout_q   <= timeout_d;
      if (tbl_we) begin
        tbl_acct_q[bus.tbl_wr_idx]  <= bus.tbl_wr_acct;
        tbl_pin_q[bus.tbl_wr_idx]   <= bus.tbl_wr_pin;
        tbl_valid_q[bus.tbl_wr_idx] <= 1'b1;
        tbl_lock_q[bus.tbl_wr_idx]  <= 1'b0;
      end
      if (lock_set) begin
        tbl_lock_q[aidx_q] <= 1'b1;
      end
    end
  end

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.acct_found    = found_q;
  assign bus.auth_ok       = auth_q;
  assign bus.acct_idx      = aidx_q;
  assign bus.fail_count    = fail_q;
  assign bus.pin_error     = pin_error_q;
  assign bus.card_reject   = reject_q;
  assign bus.card_retained = retained_q;
  assign bus.timeout       = timeout_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_atm_card_auth.sv
// Testbench for atm_card_auth: directed vectors, hand-written corner
// sequences and randomized sessions checked against an account-table model.
module tb_atm_card_auth;
  localparam int NUM  = 3;
  localparam int AW   = 12;
  localparam int PW   = 12;
  localparam int IW   = 2;
  localparam int MAXT = 3;
  localparam int TMO  = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_dbg;
  always #5 clk = ~clk;

  atm_card_auth_if #(.ACCT_W(AW), .PIN_W(PW), .IDX_W(IW)) b();

  atm_card_auth #(
    .NUM_ACCTS(NUM), .ACCT_W(AW), .PIN_W(PW), .IDX_W(IW),
    .MAX_TRIES(MAXT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (b),
    .state_o (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];   // expected session outcomes: idx=grant, 10 reject, 20 retain, 30 timeout

  // ---------------- reference model ----------------
  logic [AW-1:0] m_acct  [NUM];
  logic [PW-1:0] m_pin   [NUM];
  logic          m_valid [NUM];
  logic          m_lock  [NUM];
  int            m_fail;

  typedef struct {
    logic [AW-1:0] card;
    logic [PW-1:0] pin;
    logic          found;
    logic [IW-1:0] idx;
    int            lat;
  } vec_t;
  vec_t vecs[5];
  logic [AW-1:0] pool[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM; i++) begin
      m_acct[i] = '0; m_pin[i] = '0; m_valid[i] = 1'b0; m_lock[i] = 1'b0;
    end
    m_fail = 0;
  endtask

  // First valid entry with a matching account decides; locked -> reject.
  task automatic model_search(input logic [AW-1:0] card, output logic found,
                              output logic [IW-1:0] idx, output int lat);
    int m;
    m = -1;
    for (int i = 0; i < NUM; i++)
      if (m < 0 && m_valid[i] && m_acct[i] == card) m = i;
    if (m < 0) begin
      found = 1'b0; idx = '0; lat = NUM + 1;
    end else begin
      found = !m_lock[m]; idx = IW'(m); lat = m + 2;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic prev_auth = 1'b0;
  task automatic sb_event(input logic [7:0] ev);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_unexpected: got %0h expected none", ev);
    end else begin
      chk("sb_outcome", 32'(ev), 32'(exp_q.pop_front()));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (b.auth_ok && !prev_auth) sb_event({6'd0, b.acct_idx});
      if (b.card_retained)         sb_event(8'h20);
      if (b.card_reject)           sb_event(b.timeout ? 8'h30 : 8'h10);
    end
    prev_auth = b.auth_ok;
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [IW-1:0] idx, input logic [AW-1:0] acct,
                    input logic [PW-1:0] pin, input logic dut_idle);
    b.tbl_wr_idx = idx; b.tbl_wr_acct = acct; b.tbl_wr_pin = pin; b.tbl_wr_en = 1'b1;
    tick();
    b.tbl_wr_en = 1'b0;
    if (dut_idle && int'(idx) < NUM) begin
      m_acct[idx] = acct; m_pin[idx] = pin; m_valid[idx] = 1'b1; m_lock[idx] = 1'b0;
    end
  endtask

  task automatic insert_card(input logic [AW-1:0] card, input logic exp_found,
                             input logic [IW-1:0] exp_idx, input int lat);
    if (!exp_found) exp_q.push_back(8'h10);
    b.acct_num = card; b.card_in = 1'b1;
    tick();
    b.card_in = 1'b0; b.tbl_wr_en = 1'b0;
    m_fail = 0;
    chk("busy_search", 32'(b.busy), 32'd1);
    chk("fail_clear", 32'(b.fail_count), 32'd0);
    for (int c = 1; c <= lat; c++) begin
      tick();
      if (c < lat) begin
        chk("found_early", 32'(b.acct_found), 32'd0);
        chk("reject_early", 32'(b.card_reject), 32'd0);
      end else begin
        chk("found_at_lat", 32'(b.acct_found), 32'(exp_found));
        chk("reject_at_lat", 32'(b.card_reject), 32'(!exp_found));
        if (exp_found) chk("idx_at_lat", 32'(b.acct_idx), 32'(exp_idx));
      end
    end
    if (!exp_found) begin
      tick();
      chk("busy_after_reject", 32'(b.busy), 32'd0);
      chk("reject_one_cycle", 32'(b.card_reject), 32'd0);
    end
  endtask

  task automatic pin_attempt(input logic [PW-1:0] p, input logic [IW-1:0] idx, output int kind);
    if (p == m_pin[idx]) kind = 0;
    else begin
      m_fail++;
      kind = (m_fail >= MAXT) ? 2 : 1;
    end
    if (kind == 0) exp_q.push_back({6'd0, idx});
    if (kind == 2) exp_q.push_back(8'h20);
    repeat ($urandom_range(0, 3)) tick();
    b.pin = p; b.pin_strobe = 1'b1;
    tick();
    b.pin_strobe = 1'b0;
    chk("auth_in_check", 32'(b.auth_ok), 32'd0);
    tick();
    chk("auth_ok", 32'(b.auth_ok), 32'(kind == 0));
    chk("pin_error", 32'(b.pin_error), 32'(kind == 1));
    chk("retained", 32'(b.card_retained), 32'(kind == 2));
    chk("fail_count", 32'(b.fail_count), 32'(m_fail));
    if (kind == 2) m_lock[idx] = 1'b1;
    tick();
    chk("pulse_clear", 32'({b.pin_error, b.card_retained}), 32'd0);
    chk("found_after_pin", 32'(b.acct_found), 32'(kind != 2));
    chk("busy_after_pin", 32'(b.busy), 32'(kind != 2));
  endtask

  task automatic end_session(input logic [IW-1:0] idx);
    for (int c = 0; c < 2; c++) begin
      b.acct_num = 12'h999; b.card_in = 1'b1;
      tick();
      b.card_in = 1'b0;
      chk("auth_hold", 32'(b.auth_ok), 32'd1);
      chk("found_hold", 32'(b.acct_found), 32'd1);
      chk("idx_hold", 32'(b.acct_idx), 32'(idx));
    end
    b.session_end = 1'b1;
    tick();
    b.session_end = 1'b0;
    chk("end_found", 32'(b.acct_found), 32'd0);
    chk("end_auth", 32'(b.auth_ok), 32'd0);
    chk("end_busy", 32'(b.busy), 32'd0);
  endtask

  task automatic do_timeout();
    exp_q.push_back(8'h30);
    for (int c = 1; c <= TMO; c++) begin
      tick();
      if (c < TMO) chk("timeout_early", 32'(b.timeout), 32'd0);
      else begin
        chk("timeout_pulse", 32'(b.timeout), 32'd1);
        chk("timeout_reject", 32'(b.card_reject), 32'd1);
        chk("timeout_found", 32'(b.acct_found), 32'd0);
      end
    end
    tick();
    chk("timeout_busy_fall", 32'(b.busy), 32'd0);
    chk("timeout_one_cycle", 32'(b.timeout), 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, 32'({b.busy, b.acct_found, b.auth_ok, b.acct_idx, b.fail_count,
                 b.pin_error, b.card_reject, b.card_retained, b.timeout}), 32'd0);
  endtask

  task automatic model_card(input logic [AW-1:0] card, output logic f, output logic [IW-1:0] ix);
    int lat;
    model_search(card, f, ix, lat);
    insert_card(card, f, ix, lat);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic          f;
    logic [IW-1:0] ix;
    logic [AW-1:0] card;
    logic [PW-1:0] pk;
    int            kind;

    vecs[0] = '{card: 12'h456, pin: 12'hBBB, found: 1'b1, idx: 2'd1, lat: 3};
    vecs[1] = '{card: 12'h999, pin: 12'h000, found: 1'b0, idx: 2'd0, lat: 4};
    vecs[2] = '{card: 12'h123, pin: 12'hAAA, found: 1'b1, idx: 2'd0, lat: 2};
    vecs[3] = '{card: 12'h789, pin: 12'hCCC, found: 1'b1, idx: 2'd2, lat: 4};
    vecs[4] = '{card: 12'h000, pin: 12'h000, found: 1'b0, idx: 2'd0, lat: 4};
    pool[0] = 12'h123; pool[1] = 12'h456; pool[2] = 12'h789; pool[3] = 12'h999; pool[4] = 12'h5A5;

    rst = 1'b1;
    b.card_in = 1'b0; b.acct_num = '0; b.pin_strobe = 1'b0; b.pin = '0;
    b.session_end = 1'b0; b.tbl_wr_en = 1'b0; b.tbl_wr_idx = '0;
    b.tbl_wr_acct = '0; b.tbl_wr_pin = '0;
    model_clear();
    repeat (3) tick();
    chk_all_zero("reset_outputs");
    rst = 1'b0;
    tick();

    // Empty table: even account 0 must not match.
    insert_card(12'h000, 1'b0, 2'd0, 4);

    wr(2'd0, 12'h123, 12'hAAA, 1'b1);
    wr(2'd1, 12'h456, 12'hBBB, 1'b1);
    wr(2'd2, 12'h789, 12'hCCC, 1'b1);
    wr(2'd3, 12'h999, 12'h111, 1'b1);   // out of range, must be dropped

    for (int i = 0; i < 5; i++) begin
      insert_card(vecs[i].card, vecs[i].found, vecs[i].idx, vecs[i].lat);
      if (vecs[i].found) begin
        pin_attempt(vecs[i].pin, vecs[i].idx, kind);
        chk("vec_granted", 32'(kind), 32'd0);
        end_session(vecs[i].idx);
      end
    end

    // Two wrong PINs, then the right one.
    insert_card(12'h123, 1'b1, 2'd0, 2);
    pin_attempt(12'h111, 2'd0, kind);
    pin_attempt(12'hAAB, 2'd0, kind);
    chk("fail_count_two", 32'(b.fail_count), 32'd2);
    pin_attempt(12'hAAA, 2'd0, kind);
    end_session(2'd0);

    // Three wrong PINs retain the card; rewrite unlocks it.
    insert_card(12'h789, 1'b1, 2'd2, 4);
    for (int i = 0; i < 3; i++) pin_attempt(12'h000, 2'd2, kind);
    chk("retained_kind", 32'(kind), 32'd2);
    insert_card(12'h789, 1'b0, 2'd0, 4);
    wr(2'd2, 12'h789, 12'hCCC, 1'b1);
    insert_card(12'h789, 1'b1, 2'd2, 4);
    pin_attempt(12'hCCC, 2'd2, kind);
    end_session(2'd2);

    // Table write while busy is ignored.
    insert_card(12'h456, 1'b1, 2'd1, 3);
    wr(2'd1, 12'h456, 12'h000, 1'b0);
    pin_attempt(12'hBBB, 2'd1, kind);
    chk("busy_write_ignored", 32'(kind), 32'd0);
    end_session(2'd1);

    // Write and card_in in the same cycle: search sees new entry.
    b.tbl_wr_idx = 2'd0; b.tbl_wr_acct = 12'hABC; b.tbl_wr_pin = 12'h321; b.tbl_wr_en = 1'b1;
    m_acct[0] = 12'hABC; m_pin[0] = 12'h321; m_valid[0] = 1'b1; m_lock[0] = 1'b0;
    insert_card(12'hABC, 1'b1, 2'd0, 2);
    pin_attempt(12'h321, 2'd0, kind);
    end_session(2'd0);

    // PIN timeout.
    wr(2'd0, 12'h123, 12'hAAA, 1'b1);
    insert_card(12'h123, 1'b1, 2'd0, 2);
    do_timeout();

    // Randomized sessions against the model.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0)
        wr(IW'($urandom_range(0, 3)), pool[$urandom_range(0, 4)], PW'($urandom_range(0, 4095)), 1'b1);
      card = pool[$urandom_range(0, 4)];
      model_card(card, f, ix);
      if (f) begin
        if ($urandom_range(0, 7) == 0) do_timeout();
        else begin
          kind = 1;
          while (kind == 1) begin
            pk = ($urandom_range(0, 2) == 0) ? m_pin[ix] : (m_pin[ix] ^ PW'($urandom_range(1, 4095)));
            pin_attempt(pk, ix, kind);
          end
          if (kind == 0) end_session(ix);
        end
      end
    end

    // Reset while GRANTED clears outputs and table.
    wr(2'd0, 12'h123, 12'hAAA, 1'b1);
    insert_card(12'h123, 1'b1, 2'd0, 2);
    pin_attempt(12'hAAA, 2'd0, kind);
    rst = 1'b1;
    tick();
    chk_all_zero("reset_in_granted");
    rst = 1'b0;
    model_clear();
    insert_card(12'h123, 1'b0, 2'd0, 4);

    repeat (2) tick();
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
